// File: rtl/scan_decoder.sv
// One-hot decoder with direct select and auto-scan modes.
// Scan mode holds each index for dwell+1 cycles and pulses wrap on rollover to 0.
module scan_decoder #(
    parameter int N  = 3,
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            e,
    input  logic            mode,
    input  logic [N-1:0]    in,
    input  logic [DW-1:0]   dwell,
    output logic [2**N-1:0] out,
    output logic [N-1:0]    idx,
    output logic            valid,
    output logic            wrap
);
    localparam int OW = 2**N;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] cnt_reg, cnt_next;
    logic [N-1:0]  idx_next;
    logic          valid_next;
    logic          wrap_next;
    logic [OW-1:0] out_next;

    always_comb begin
        state_next = IDLE;
        idx_next   = idx;
        cnt_next   = '0;
        valid_next = 1'b0;
        wrap_next  = 1'b0;
        if (e) begin
            valid_next = 1'b1;
            if (!mode) begin
                state_next = DIRECT;
                idx_next   = in;
            end else begin
                state_next = SCAN;
                // Comparing against the live dwell with >= lets a lowered
                // dwell take effect immediately and keeps cnt from overflowing.
                if (state_reg != SCAN) begin
                    idx_next = in;
                end else if (cnt_reg >= dwell) begin
                    idx_next  = idx + N'(1);
                    wrap_next = (idx == {N{1'b1}});
                end else begin
                    cnt_next = cnt_reg + DW'(1);
                end
            end
        end
    end

    // MSB-first mapping: index k lights out[OW-1-k].
    generate
        for (genvar gi = 0; gi < OW; gi++) begin : g_onehot
            assign out_next[gi] = valid_next && (idx_next == N'(OW - 1 - gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx       <= '0;
            out       <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx       <= idx_next;
            out       <= out_next;
            valid     <= valid_next;
            wrap      <= wrap_next;
        end
    end
endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: directed scenarios plus a randomized
// run compared against a behavioural model of the select/scan rules.
module tb_scan_decoder;
    localparam int N  = 3;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          e = 1'b0;
    logic          mode = 1'b0;
    logic [N-1:0]  in = '0;
    logic [DW-1:0] dwell = '0;
    logic [7:0]    out;
    logic [N-1:0]  idx;
    logic          valid;
    logic          wrap;

    int checks = 0;
    int errors = 0;

    // Model: 0 = idle, 1 = direct, 2 = scan
    int m_st   = 0;
    int m_idx  = 0;
    int m_cnt  = 0;
    bit m_wrap = 1'b0;

    scan_decoder #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .e(e), .mode(mode), .in(in), .dwell(dwell),
        .out(out), .idx(idx), .valid(valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] onehot(input int k);
        logic [7:0] base;
        base = 8'h80;
        return base >> k;
    endfunction

    task automatic cycle(input bit r, input bit ie, input bit im, input int iin, input int idw);
        rst = r; e = ie; mode = im; in = iin[2:0]; dwell = idw[3:0];
        @(posedge clk);
        if (r) begin
            m_st = 0; m_idx = 0; m_cnt = 0; m_wrap = 0;
        end else if (!ie) begin
            m_st = 0; m_cnt = 0; m_wrap = 0;
        end else if (!im) begin
            m_st = 1; m_idx = iin % 8; m_cnt = 0; m_wrap = 0;
        end else if (m_st != 2) begin
            m_st = 2; m_idx = iin % 8; m_cnt = 0; m_wrap = 0;
        end else if (m_cnt >= idw) begin
            m_wrap = (m_idx == 7);
            m_idx = (m_idx + 1) % 8;
            m_cnt = 0;
        end else begin
            m_cnt++; m_wrap = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 5, 3);
        cycle(1, 1, 0, 6, 0);
        checks++;
        if ({out, idx, valid, wrap} !== 13'd0) begin
            errors++;
            $display("FAIL reset out=%h idx=%0d valid=%b wrap=%b required 00/0/0/0", out, idx, valid, wrap);
        end
        $display("reset: out=%h idx=%0d valid=%b", out, idx, valid);
    endtask

    task automatic test_direct_sweep();
        for (int k = 0; k < 8; k++) begin
            cycle(0, 1, 0, k, $urandom_range(15));
            checks++;
            if ({out, idx, valid, wrap} !== {onehot(k), 3'(k), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL direct_%0d out=%h idx=%0d valid=%b wrap=%b required %h/%0d/1/0",
                         k, out, idx, valid, wrap, onehot(k), k);
            end
            $display("direct: in=%0d out=%h idx=%0d", k, out, idx);
        end
    endtask

    task automatic test_enable_off();
        cycle(0, 1, 0, 3, 0);
        cycle(0, 0, 0, 3, 0);
        checks++;
        if ({out, idx, valid, wrap} !== {8'h00, 3'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL enable_off out=%h idx=%0d valid=%b wrap=%b required 00/3/0/0", out, idx, valid, wrap);
        end
        $display("enable_off: out=%h idx=%0d valid=%b", out, idx, valid);
    endtask

    task automatic test_scan_dwell2();
        int exp_idx [10] = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 1, (i == 0) ? 6 : int'($urandom_range(7)), 2);
            checks++;
            if ({out, idx, valid, wrap} !== {onehot(exp_idx[i]), 3'(exp_idx[i]), 1'b1, 1'(i == 6)}) begin
                errors++;
                $display("FAIL scan_dwell2_%0d out=%h idx=%0d valid=%b wrap=%b required idx=%0d wrap=%b",
                         i, out, idx, valid, wrap, exp_idx[i], (i == 6));
            end
            $display("scan_dwell2: cyc=%0d idx=%0d wrap=%b", i, idx, wrap);
        end
    endtask

    task automatic test_scan_dwell0();
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            cycle(0, 1, 1, (i == 0) ? 0 : int'($urandom_range(7)), 0);
            checks++;
            if ({out, idx, valid, wrap} !== {onehot(i % 8), 3'(i % 8), 1'b1, 1'(i > 0 && i % 8 == 0)}) begin
                errors++;
                $display("FAIL scan_dwell0_%0d out=%h idx=%0d wrap=%b required idx=%0d wrap=%b",
                         i, out, idx, wrap, i % 8, (i > 0 && i % 8 == 0));
            end
            $display("scan_dwell0: cyc=%0d idx=%0d wrap=%b", i, idx, wrap);
        end
    endtask

    task automatic test_live_dwell();
        int exp_tail [3] = '{3, 3, 4};
        cycle(0, 1, 0, 2, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, 2, 9);
            checks++;
            if (idx !== 3'd2 || out !== 8'h20) begin
                errors++;
                $display("FAIL live_dwell_hold_%0d idx=%0d out=%h required 2/20", i, idx, out);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 7, 1);
            checks++;
            if (idx !== 3'(exp_tail[i]) || out !== onehot(exp_tail[i])) begin
                errors++;
                $display("FAIL live_dwell_step_%0d idx=%0d out=%h required %0d", i, idx, out, exp_tail[i]);
            end
            $display("live_dwell: step=%0d idx=%0d", i, idx);
        end
    endtask

    task automatic test_reset_mid_scan();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 5, 9);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1, 9);
        cycle(1, 1, 1, 2, 9);
        checks++;
        if ({out, idx, valid, wrap} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_scan out=%h idx=%0d valid=%b required 00/0/0", out, idx, valid);
        end
        cycle(0, 1, 1, 4, 1);
        checks++;
        if ({out, idx, valid, wrap} !== {8'h08, 3'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL restart_entry out=%h idx=%0d valid=%b wrap=%b required 08/4/1/0", out, idx, valid, wrap);
        end
        cycle(0, 1, 1, 0, 1);
        checks++;
        if (idx !== 3'd4) begin
            errors++;
            $display("FAIL restart_cnt0 idx=%0d required 4", idx);
        end
        $display("reset_mid_scan: restarted idx=%0d", idx);
    endtask

    task automatic test_random();
        bit r_mode = 1'b1;
        int r_dw = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) r_mode = ~r_mode;
            if ($urandom_range(15) == 0) r_dw = $urandom_range(15);
            else if ($urandom_range(7) == 0) r_dw = $urandom_range(3);
            cycle($urandom_range(39) == 0, $urandom_range(9) != 0, r_mode,
                  $urandom_range(7), r_dw);
            checks++;
            if ({out, idx, valid, wrap} !== {(m_st == 0) ? 8'h00 : onehot(m_idx), 3'(m_idx), 1'(m_st != 0), m_wrap}) begin
                errors++;
                $display("FAIL random_%0d out=%h idx=%0d valid=%b wrap=%b required idx=%0d valid=%b wrap=%b",
                         i, out, idx, valid, wrap, m_idx, (m_st != 0), m_wrap);
            end
        end
        $display("random: 400 cycles done");
    endtask

    initial begin
        test_reset();
        test_direct_sweep();
        test_enable_off();
        test_scan_dwell2();
        test_scan_dwell0();
        test_live_dwell();
        test_reset_mid_scan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
